store_write_buffer: RTL and testbench

// Store-side counterpart of the load/immediate extenders: narrows sb/sh/sw data

---
 rtl/store_write_buffer.sv | 131 +++++++++++++
 tb/tb_store_write_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// Store write buffer: narrows sb/sh/sw into word-aligned lane writes with byte enables,
// flags misaligned stores, and drains accepted stores in order over a req/ack bus.
module store_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        exc_valid,
    output logic [31:0] exc_addr,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [29:0]   addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          exc_valid_q;
    logic [31:0]   exc_addr_q;

    logic          full;
    logic          legal;
    logic          attempt;
    logic          push;
    logic          pop;
    logic [31:0]   new_wdata;
    logic [3:0]    new_be;

    // Alignment check and lane formation for the presented store
    always_comb begin
        legal     = 1'b0;
        new_wdata = st_data;
        new_be    = 4'b0000;
        case (st_size)
            2'b00: begin
                legal     = 1'b1;
                new_wdata = {4{st_data[7:0]}};
                new_be    = 4'b0001 << st_addr[1:0];
            end
            2'b01: begin
                legal     = ~st_addr[0];
                new_wdata = {2{st_data[15:0]}};
                new_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal     = (st_addr[1:0] == 2'b00);
                new_wdata = st_data;
                new_be    = 4'b1111;
            end
            default: begin
                legal     = 1'b0;
                new_wdata = st_data;
                new_be    = 4'b0000;
            end
        endcase
    end

    assign full     = (count_q == CW'(DEPTH));
    assign st_ready = ~full;
    assign attempt  = st_valid & st_ready;
    assign push     = attempt & legal;
    assign pop      = bus_req & bus_ack;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            exc_valid_q <= attempt & ~legal;
            if (attempt & ~legal) begin
                exc_addr_q <= st_addr;
            end
        end
    end

    // Storage needs no reset: the head is only visible while count is non-zero
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= st_addr[31:2];
            data_mem[wr_ptr_q] <= new_wdata;
            be_mem[wr_ptr_q]   <= new_be;
        end
    end

    assign empty     = (count_q == '0);
    assign bus_req   = ~empty;
    assign bus_addr  = bus_req ? {addr_mem[rd_ptr_q], 2'b00} : 32'h0;
    assign bus_wdata = bus_req ? data_mem[rd_ptr_q] : 32'h0;
    assign bus_be    = bus_req ? be_mem[rd_ptr_q] : 4'h0;
    assign exc_valid = exc_valid_q;
    assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer: expected bus writes are queued as stores are
// driven and compared as each write is handshaken on the bus.
module tb_store_write_buffer;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        exc_valid;
    logic [31:0] exc_addr;
    logic        bus_req;
    logic        bus_ack;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        empty;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  pops = 0;

    store_write_buffer #(.DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_size  (st_size),
        .exc_valid(exc_valid),
        .exc_addr (exc_addr),
        .bus_req  (bus_req),
        .bus_ack  (bus_ack),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_be   (bus_be),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic wr_t lanes(input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] s);
        wr_t w;
        w.addr = {a[31:2], 2'b00};
        case (s)
            2'b00:   begin w.wdata = {4{d[7:0]}};  w.be = 4'b0001 << a[1:0]; end
            2'b01:   begin w.wdata = {2{d[15:0]}}; w.be = a[1] ? 4'b1100 : 4'b0011; end
            default: begin w.wdata = d;            w.be = 4'b1111; end
        endcase
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_size  = s;
    endtask

    task automatic wait_empty(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (empty) break;
        end
        chk(tag, {31'b0, empty}, 32'd1);
    endtask

    // Scoreboard: every completed handshake must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && bus_req && bus_ack) begin
            wr_t e;
            pops++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", bus_addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("bus_addr", bus_addr, e.addr);
                chk("bus_wdata", bus_wdata, e.wdata);
                chk("bus_be", {28'b0, bus_be}, {28'b0, e.be});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_size  = '0;
        bus_ack  = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("rst_st_ready", {31'b0, st_ready}, 32'd1);
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_be", {28'b0, bus_be}, 32'h0);
        chk("rst_exc_valid", {31'b0, exc_valid}, 32'd0);
        chk("rst_exc_addr", exc_addr, 32'h0);
        step();
        reset   = 1'b0;
        bus_ack = 1'b1;

        // sb to the top byte lane
        drive(32'h0000_1003, 32'h1234_56AB, 2'b00);
        exp_q.push_back('{32'h0000_1000, 32'hABAB_ABAB, 4'b1000});
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("sb_req", {31'b0, bus_req}, 32'd1);
        chk("sb_empty", {31'b0, empty}, 32'd0);
        step();
        @(negedge clk);
        chk("sb_empty_after", {31'b0, empty}, 32'd1);
        chk("sb_req_after", {31'b0, bus_req}, 32'd0);
        step();

        // sh upper half, then misaligned sh
        drive(32'h0000_2002, 32'h0000_BEEF, 2'b01);
        exp_q.push_back('{32'h0000_2000, 32'hBEEF_BEEF, 4'b1100});
        step();
        drive(32'h0000_2001, 32'h0000_BEEF, 2'b01);
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("sh_mis_exc", {31'b0, exc_valid}, 32'd1);
        chk("sh_mis_addr", exc_addr, 32'h0000_2001);
        chk("sh_mis_no_req", {31'b0, bus_req}, 32'd0);
        step();
        @(negedge clk);
        chk("sh_mis_pulse_end", {31'b0, exc_valid}, 32'd0);
        step();

        // reserved size at an aligned address
        drive(32'h0000_0020, 32'hDEAD_BEEF, 2'b11);
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("rsv_exc", {31'b0, exc_valid}, 32'd1);
        chk("rsv_addr", exc_addr, 32'h0000_0020);
        chk("rsv_empty", {31'b0, empty}, 32'd1);
        step();

        // fill with ack low, hold a fifth store, then drain
        bus_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 2'b10);
            exp_q.push_back('{32'h10 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'b1111});
            step();
        end
        drive(32'h0000_0020, 32'hC0DE_0004, 2'b10);
        exp_q.push_back('{32'h0000_0020, 32'hC0DE_0004, 4'b1111});
        @(negedge clk);
        chk("full_ready", {31'b0, st_ready}, 32'd0);
        chk("full_head", bus_addr, 32'h0000_0010);
        step();
        step();
        bus_ack = 1'b1;
        @(negedge clk);
        chk("full_ack_no_pass", {31'b0, st_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("ready_after_pop", {31'b0, st_ready}, 32'd1);
        step();
        st_valid = 1'b0;
        wait_empty("drain_empty", 20);
        chk("drain_all_popped", 32'(exp_q.size()), 32'd0);
        step();

        // steady push+pop across pointer wrap
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [1:0]  s;
            s = 2'(i % 3);
            a = 32'h100 + 32'(8 * i) + ((s == 2'b00) ? 32'(i % 4) :
                                        (s == 2'b01) ? 32'(2 * (i % 2)) : 32'h0);
            drive(a, 32'hA5C3_0000 ^ (32'h0101_0101 * 32'(i + 1)), s);
            exp_q.push_back(lanes(a, 32'hA5C3_0000 ^ (32'h0101_0101 * 32'(i + 1)), s));
            @(negedge clk);
            if (i > 0) begin
                chk("stream_empty", {31'b0, empty}, 32'd0);
                chk("stream_ready", {31'b0, st_ready}, 32'd1);
            end
            step();
        end
        st_valid = 1'b0;
        wait_empty("stream_drain", 10);
        chk("stream_all_popped", 32'(exp_q.size()), 32'd0);
        step();

        // reset with entries in flight
        bus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h200 + 32'(4 * i), 32'h5555_0000 + 32'(i), 2'b10);
            step();
        end
        st_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst2_req", {31'b0, bus_req}, 32'd0);
        chk("rst2_empty", {31'b0, empty}, 32'd1);
        chk("rst2_ready", {31'b0, st_ready}, 32'd1);
        chk("rst2_addr", bus_addr, 32'h0);
        chk("rst2_exc_addr", exc_addr, 32'h0);
        step();
        bus_ack = 1'b1;
        drive(32'h0000_0040, 32'h0000_0077, 2'b00);
        exp_q.push_back('{32'h0000_0040, 32'h7777_7777, 4'b0001});
        step();
        st_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_req", {31'b0, bus_req}, 32'd1);
        wait_empty("post_rst_drain", 10);
        chk("post_rst_popped", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
